// File: rtl/full_adder_1bit_checker.sv
// full_adder_1bit_checker
//   Response checker for a registered 1-bit full adder. It samples the same
//   {cin,a,b} stimulus as the adder and predicts {sum,cout}. The prediction is
//   delayed by LATENCY clocks and then compared with the adder outputs. It
//   reports check and mismatch counts, a sticky error flag and the first
//   failing vector.
//
// Parameters
//   LATENCY : adder clocks from stimulus sample to valid sum/cout (1..8)
//   CNT_W   : width of the check and error counters
//
// Ports
//   clk        in   sampling clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear of counters, err and first_* (FSM untouched)
//   chk_en     in   a/b/cin carry a valid vector this cycle
//   a, b, cin  in   adder stimulus
//   sum, cout  in   adder outputs under test
//   busy       out  predictions in flight (state RUN or DRAIN)
//   chk_cnt    out  comparisons performed, saturating
//   err_cnt    out  mismatches seen, saturating
//   err        out  sticky mismatch flag
//   mis        out  one-cycle pulse per mismatch
//   first_stim out  {cin,a,b} of the first mismatch
//   first_obs  out  {sum,cout} observed at the first mismatch
module full_adder_1bit_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             chk_en,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err,
  output logic             mis,
  output logic [2:0]       first_stim,
  output logic [1:0]       first_obs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;

  // Prediction pipeline: stage 0 is the newest sample, stage LATENCY-1 the tail.
  logic       valid_reg [LATENCY];
  logic [1:0] exp_reg   [LATENCY];
  logic [2:0] stim_reg  [LATENCY];

  logic       exp_sum;
  logic       exp_cout;
  logic       tail_valid;
  logic       mismatch;
  logic       pending;

  logic [CNT_W-1:0] chk_cnt_next;
  logic [CNT_W-1:0] err_cnt_next;
  logic             err_next;
  logic [2:0]       first_stim_next;
  logic [1:0]       first_obs_next;

  assign exp_sum  = a ^ b ^ cin;
  assign exp_cout = (a & b) | (a & cin) | (b & cin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        exp_reg[i]   <= 2'b00;
        stim_reg[i]  <= 3'b000;
      end
    end else begin
      valid_reg[0] <= chk_en;
      exp_reg[0]   <= {exp_sum, exp_cout};
      stim_reg[0]  <= {cin, a, b};
      for (int i = 1; i < LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        exp_reg[i]   <= exp_reg[i-1];
        stim_reg[i]  <= stim_reg[i-1];
      end
    end
  end

  assign tail_valid = valid_reg[LATENCY-1];
  // Case-inequality so that X/Z on the adder outputs is reported as a mismatch.
  assign mismatch   = tail_valid && ({sum, cout} !== exp_reg[LATENCY-1]);

  // Valid entries that will still be in the pipe after this edge; the tail is
  // excluded because it is being compared now.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      pending = pending | valid_reg[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (chk_en) state_next = RUN;
      RUN:     if (!chk_en) state_next = pending ? DRAIN : IDLE;
      DRAIN: begin
        if (chk_en)       state_next = RUN;
        else if (!pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // clr is applied first so that a compare on the same edge is still counted.
  always_comb begin
    chk_cnt_next    = chk_cnt;
    err_cnt_next    = err_cnt;
    err_next        = err;
    first_stim_next = first_stim;
    first_obs_next  = first_obs;
    if (clr) begin
      chk_cnt_next    = '0;
      err_cnt_next    = '0;
      err_next        = 1'b0;
      first_stim_next = 3'b000;
      first_obs_next  = 2'b00;
    end
    if (tail_valid && (chk_cnt_next != CNT_MAX)) begin
      chk_cnt_next = chk_cnt_next + CNT_W'(1);
    end
    if (mismatch) begin
      if (err_cnt_next != CNT_MAX) begin
        err_cnt_next = err_cnt_next + CNT_W'(1);
      end
      if (!err_next) begin
        first_stim_next = stim_reg[LATENCY-1];
        first_obs_next  = {sum, cout};
      end
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      chk_cnt    <= '0;
      err_cnt    <= '0;
      err        <= 1'b0;
      mis        <= 1'b0;
      first_stim <= 3'b000;
      first_obs  <= 2'b00;
    end else begin
      state_reg  <= state_next;
      chk_cnt    <= chk_cnt_next;
      err_cnt    <= err_cnt_next;
      err        <= err_next;
      mis        <= mismatch;
      first_stim <= first_stim_next;
      first_obs  <= first_obs_next;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
